// File: rtl/write_back_buffer.sv
// write_back_buffer
// Posted-write FIFO between the cache controller and the RAM. Dirty-line
// write-backs are queued and retired to RAM in the background; miss reads are
// served from the youngest matching buffered entry, otherwise from RAM.
//
// Ports:
//   clock, resetn          clock, asynchronous active-low reset
//   wr_valid/wr_addr/
//   wr_data/wr_ready       write-back push from the cache
//   rd_req/rd_addr/
//   rd_ready               miss read request from the cache
//   rd_valid/rd_data       one-cycle read-return pulse and its data
//   ram_addr/ram_data/
//   ram_wren/ram_q         RAM port (ram_q valid one clock after address)
//   count, state           occupancy and FSM code for the debug displays
//
// Handshakes: a write is taken at a clock edge where wr_valid & wr_ready
// (wr_ready = not full, in every state); the cache holds wr_valid and its
// payload until then. A read is taken at an edge where rd_req & rd_ready
// (rd_ready = FSM idle); the answer arrives as a single-cycle rd_valid pulse.
//
// Build option: define WBB_COALESCE_EN to merge a push into an existing entry
// with the same address instead of allocating a new one.
module write_back_buffer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   wr_valid,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   wr_ready,
    input  logic                   rd_req,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_data,
    output logic                   ram_wren,
    input  logic [DATA_W-1:0]      ram_q,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2,
        RWAIT = 2'd3
    } state_t;

    state_t            fsm_q;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_vld;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_next;
    logic [ADDR_W-1:0] rd_addr_q;

    logic              pop;
    logic              push;
    logic              alloc;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign wr_ready = (count_q != CNT_W'(DEPTH));
    assign rd_ready = (fsm_q == IDLE);
    assign pop      = (fsm_q == DRAIN);
    assign push     = wr_valid && wr_ready;
    assign count    = count_q;
    assign state    = fsm_q;

    // Forwarding search walks oldest to youngest so the last hit is the
    // youngest entry. It looks at the registered entries only, so a write
    // pushed on the same edge as the read is not visible to it.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[head + PTR_W'(i)] && (ent_addr[head + PTR_W'(i)] == rd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data[head + PTR_W'(i)];
            end
        end
    end

`ifdef WBB_COALESCE_EN
    logic             co_hit;
    logic [PTR_W-1:0] co_idx;

    // The head leaving on this edge cannot absorb the write: its old data is
    // what goes to RAM now, so the new data needs its own entry.
    always_comb begin
        co_hit = 1'b0;
        co_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && (ent_addr[i] == wr_addr) && !(pop && (PTR_W'(i) == head))) begin
                co_hit = 1'b1;
                co_idx = PTR_W'(i);
            end
        end
    end

    assign alloc = push && !co_hit;
`else
    assign alloc = push;
`endif

    always_comb begin
        count_next = count_q;
        if (alloc && !pop) begin
            count_next = count_q + CNT_W'(1);
        end else if (pop && !alloc) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    // Entry storage and pointers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
            ent_vld <= '0;
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            if (alloc) begin
                ent_addr[tail] <= wr_addr;
                ent_data[tail] <= wr_data;
                ent_vld[tail]  <= 1'b1;
                tail           <= tail + PTR_W'(1);
            end
`ifdef WBB_COALESCE_EN
            else if (push) begin
                ent_data[co_idx] <= wr_data;
            end
`endif
            count_q <= count_next;
        end
    end

    // Control FSM. A read in IDLE takes priority over starting a drain, and
    // a pending rd_req ends a drain burst so the read gets in next.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fsm_q     <= IDLE;
            rd_addr_q <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_valid <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (rd_req) begin
                        if (fwd_hit) begin
                            rd_valid <= 1'b1;
                            rd_data  <= fwd_data;
                        end else begin
                            rd_addr_q <= rd_addr;
                            fsm_q     <= READ;
                        end
                    end else if (count_q != '0) begin
                        fsm_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    fsm_q <= ((count_next != '0) && !rd_req) ? DRAIN : IDLE;
                end
                READ: begin
                    fsm_q <= RWAIT;
                end
                RWAIT: begin
                    rd_data  <= ram_q;
                    rd_valid <= 1'b1;
                    fsm_q    <= IDLE;
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    // RAM bus decoded from registered state, entries and latched address.
    always_comb begin
        ram_addr = '0;
        ram_data = '0;
        ram_wren = 1'b0;
        case (fsm_q)
            DRAIN: begin
                ram_addr = ent_addr[head];
                ram_data = ent_data[head];
                ram_wren = 1'b1;
            end
            READ: begin
                ram_addr = rd_addr_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_write_back_buffer.sv
// Testbench for write_back_buffer: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based reference model.
module tb_write_back_buffer;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int EW     = ADDR_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic resetn;

    always #5 clock = ~clock;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    logic [2:0]        count;
    logic [1:0]        state;

    write_back_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q),
        .count    (count),
        .state    (state)
    );

    // ---------------- RAM behind the buffer ----------------
    function automatic logic [DATA_W-1:0] ram_init(input int a);
        if (a == 12) return 8'h9E;
        return DATA_W'(a * 29 + 3);
    endfunction

    logic [DATA_W-1:0] tb_ram [32];
    bit                tb_wr  [32];
    int                n_ram_wr = 0;

    always @(posedge clock) begin
        if (ram_wren) begin
            tb_ram[ram_addr] <= ram_data;
            tb_wr[ram_addr]  <= 1'b1;
            n_ram_wr         <= n_ram_wr + 1;
        end
        ram_q <= tb_wr[ram_addr] ? tb_ram[ram_addr] : ram_init(int'(ram_addr));
    end

    function automatic logic [DATA_W-1:0] ram_word(input int a);
        return tb_wr[a] ? tb_ram[a] : ram_init(a);
    endfunction

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds {addr,data} of writes still owed to RAM, oldest first.
    logic [EW-1:0]     exp_q[$];
    int                m_state;
    logic [ADDR_W-1:0] m_rd_addr;
    logic [DATA_W-1:0] m_rd_q;
    logic [DATA_W-1:0] m_rd_data;
    bit                m_rd_valid;
    logic [DATA_W-1:0] m_ram [32];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state    = 0;
        m_rd_addr  = '0;
        m_rd_q     = '0;
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
    endtask

    // One clock edge of the model, using the inputs in force at that edge.
    task automatic model_edge();
        int            st = m_state;
        int            n  = exp_q.size();
        bit            hit = 1'b0;
        bit            merged = 1'b0;
        logic [DATA_W-1:0] hd = '0;
        logic [EW-1:0] e;
        for (int i = 0; i < n; i++) begin
            e = exp_q[i];
            if (e[EW-1:DATA_W] == rd_addr) begin
                hit = 1'b1;
                hd  = e[DATA_W-1:0];
            end
        end
        m_rd_valid = 1'b0;
        if (st == 1) begin
            e = exp_q.pop_front();
            m_ram[e[EW-1:DATA_W]] = e[DATA_W-1:0];
        end
        if (wr_valid && n != DEPTH) begin
`ifdef WBB_COALESCE_EN
            for (int i = 0; i < exp_q.size(); i++) begin
                e = exp_q[i];
                if (e[EW-1:DATA_W] == wr_addr) begin
                    exp_q[i] = {wr_addr, wr_data};
                    merged   = 1'b1;
                end
            end
`endif
            if (!merged) exp_q.push_back({wr_addr, wr_data});
        end
        case (st)
            0: begin
                if (rd_req) begin
                    if (hit) begin
                        m_rd_valid = 1'b1;
                        m_rd_data  = hd;
                    end else begin
                        m_rd_addr = rd_addr;
                        m_state   = 2;
                    end
                end else if (n > 0) begin
                    m_state = 1;
                end
            end
            1: m_state = (exp_q.size() > 0 && !rd_req) ? 1 : 0;
            2: begin
                m_state = 3;
                m_rd_q  = m_ram[m_rd_addr];
            end
            default: begin
                m_state    = 0;
                m_rd_valid = 1'b1;
                m_rd_data  = m_rd_q;
            end
        endcase
    endtask

    task automatic check_outputs();
        logic [EW-1:0] hd;
        check("count", 32'(count), 32'(exp_q.size()));
        check("wr_ready", 32'(wr_ready), 32'(exp_q.size() != DEPTH));
        check("rd_ready", 32'(rd_ready), 32'(m_state == 0));
        check("state", 32'(state), 32'(m_state));
        check("ram_wren", 32'(ram_wren), 32'(m_state == 1));
        if (m_state == 1 && exp_q.size() > 0) begin
            hd = exp_q[0];
            check("drain_addr", 32'(ram_addr), 32'(hd[EW-1:DATA_W]));
            check("drain_data", 32'(ram_data), 32'(hd[DATA_W-1:0]));
        end
        if (m_state == 2) check("read_addr", 32'(ram_addr), 32'(m_rd_addr));
        check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        check("rd_data", 32'(rd_data), 32'(m_rd_data));
    endtask

    // ---------------- driver tasks ----------------
    // Entered and left at a falling edge.
    task automatic step(input bit wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input bit rq, input logic [ADDR_W-1:0] ra);
        check_outputs();
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_req   = rq;
        rd_addr  = ra;
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic apply_reset();
        resetn   = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_data", 32'(ram_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        bit accepted;
        resetn   = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        for (int i = 0; i < 32; i++) m_ram[i] = ram_init(i);
        model_reset();
        @(negedge clock);
        apply_reset();

        // Three pushes drain in order, one RAM write per cycle.
        base = n_ram_wr;
        step(1'b1, 5'd3, 8'hA1, 1'b0, '0);
        step(1'b1, 5'd7, 8'hB2, 1'b0, '0);
        step(1'b1, 5'd3, 8'hC3, 1'b0, '0);
        idle(6);
        check("t1_writes", 32'(n_ram_wr - base), 32'd3);
        check("t1_ram3", 32'(ram_word(3)), 32'hC3);
        check("t1_ram7", 32'(ram_word(7)), 32'hB2);

        // Fill while read hits keep the FSM idle; a held write waits for a pop.
        step(1'b1, 5'd1, 8'h10, 1'b0, '0);
        step(1'b1, 5'd2, 8'h20, 1'b1, 5'd1);
        step(1'b1, 5'd3, 8'h30, 1'b1, 5'd1);
        step(1'b1, 5'd4, 8'h40, 1'b1, 5'd2);
        check("t2_full_ready", 32'(wr_ready), 32'd0);
        check("t2_full_count", 32'(count), 32'd4);
        step(1'b1, 5'd9, 8'h55, 1'b1, 5'd3);
        check("t2_held_count", 32'(count), 32'd4);
        accepted = 1'b0;
        for (int k = 0; k < 10 && !accepted; k++) begin
            accepted = wr_ready;
            step(1'b1, 5'd9, 8'h55, 1'b0, '0);
        end
        check("t2_accept", 32'(accepted), 32'd1);
        idle(8);
        check("t2_ram9", 32'(ram_word(9)), 32'h55);

        // Forwarding: same-edge push unseen, then the youngest entry wins.
        base = n_ram_wr;
        step(1'b1, 5'd5, 8'h11, 1'b0, '0);
        step(1'b1, 5'd5, 8'h22, 1'b1, 5'd5);
        check("t3_fwd_old", 32'(rd_data), 32'h11);
        step(1'b0, '0, '0, 1'b1, 5'd5);
        check("t3_fwd_valid", 32'(rd_valid), 32'd1);
        check("t3_fwd_young", 32'(rd_data), 32'h22);
        check("t3_no_wren", 32'(n_ram_wr - base), 32'd0);
        idle(6);

        // Miss read from RAM word 12.
        step(1'b0, '0, '0, 1'b1, 5'd12);
        check("t4_read", 32'(state), 32'd2);
        step(1'b0, '0, '0, 1'b0, '0);
        check("t4_rwait", 32'(state), 32'd3);
        check("t4_not_yet", 32'(rd_valid), 32'd0);
        step(1'b0, '0, '0, 1'b0, '0);
        check("t4_valid", 32'(rd_valid), 32'd1);
        check("t4_data", 32'(rd_data), 32'h9E);
        idle(2);

        // Reset in the middle of a two-entry drain.
        step(1'b1, 5'd10, 8'hAA, 1'b0, '0);
        step(1'b1, 5'd11, 8'hBB, 1'b0, '0);
        check("t5_draining", 32'(ram_wren), 32'd1);
        base = n_ram_wr;
        apply_reset();
        idle(4);
        check("t5_no_wren", 32'(n_ram_wr - base), 32'd0);
        check("t5_ram10", 32'(ram_word(10)), 32'(ram_init(10)));
        check("t5_ram11", 32'(ram_word(11)), 32'(ram_init(11)));

`ifdef WBB_COALESCE_EN
        // Same-address pushes merge into one entry.
        base = n_ram_wr;
        step(1'b1, 5'd6, 8'h01, 1'b0, '0);
        step(1'b1, 5'd6, 8'h02, 1'b1, 5'd6);
        check("t6_count", 32'(count), 32'd1);
        idle(4);
        check("t6_writes", 32'(n_ram_wr - base), 32'd1);
        check("t6_ram6", 32'(ram_word(6)), 32'h02);
`endif

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                step(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                     DATA_W'($urandom_range(0, 255)), ($urandom_range(0, 9) < 3),
                     ADDR_W'($urandom_range(0, 15)));
            end
        end
        idle(10);
        for (int i = 0; i < 32; i++) check("ram_final", 32'(ram_word(i)), 32'(m_ram[i]));

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
